// File: rtl/gpp_boot_loader_pkg.sv
// gpp_boot_loader_pkg
//   Shared definitions for the GPP boot loader.
//   - state_e   : loader FSM encoding. S_VERIFY exists only in builds with
//                 GPP_BOOT_LOADER_VERIFY_EN defined; the encoding is fixed so
//                 debug tooling sees the same values in every build.
//   - STATE_W   : width of the exported debug state.
//   - is_busy() : Busy decode shared by RTL and bench.
package gpp_boot_loader_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 3'd0,
    S_MEMRST = 3'd1,
    S_LOAD   = 3'd2,
    S_GAP    = 3'd3,
    S_VERIFY = 3'd4,
    S_CPURST = 3'd5,
    S_RUN    = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  // Busy is everything except the two resting states.
  function automatic logic is_busy(input state_e s);
    return !((s == S_IDLE) || (s == S_DONE));
  endfunction

endpackage

// File: rtl/gpp_sat_counter.sv
// gpp_sat_counter
//   Saturating up-counter used for the GPP run-cycle measurement.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset (count -> 0)
//     clr  : synchronous clear, has priority over en
//     en   : count enable; the count sticks at all-ones once reached
//     cnt  : registered count value
module gpp_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/gpp_boot_loader.sv
// gpp_boot_loader
//   Loads a program image from a valid/ready word stream into the GPP
//   instruction SRAM, then resets and starts the GPP, waits for Done and
//   reports the run length.
//
//   Optional feature macro: GPP_BOOT_LOADER_VERIFY_EN
//     When defined, the loader XORs every written word into a checksum, reads
//     the whole image back (S_VERIFY) and only boots the GPP if the read-back
//     checksum matches; otherwise it raises Verify_Err and stops in S_DONE.
//
//   Ports:
//     Clk, Rst          : clock, synchronous active-high reset
//     Go                : start/restart request (honoured in S_IDLE/S_DONE)
//     Img_Valid/Img_Data/Img_Ready : image word stream (see handshake below)
//     Rst_M, Addr, Data_I, En, RW  : SRAM load port to GPP_TOP (RW 1 = write)
//     Data_O            : SRAM read data (read-back verification only)
//     Gpp_Rst, Gpp_Str, Gpp_Done   : GPP core control
//     Busy              : not in S_IDLE/S_DONE
//     Finished          : sticky run (or failed verify) complete
//     Run_Cycles        : S_RUN cycles up to and including the Done cycle
//     Verify_Err        : (feature builds) sticky checksum mismatch
//     Dbg_State         : current FSM state for debug/checkers
//
//   Handshake: a word transfers on every rising Clk edge where Img_Valid and
//   Img_Ready are both high. Img_Ready depends only on loader state, never on
//   Img_Valid. The producer must hold Img_Data stable while Img_Valid is high
//   and Img_Ready is low.
//
//   All outputs come straight from flops; each *_d value is computed for the
//   state being entered, so an output belongs to the state it is seen in.
module gpp_boot_loader
  import gpp_boot_loader_pkg::*;
#(
  parameter int D_WIDTH   = 32,
  parameter int SA_WIDTH  = 5,
  parameter int NUM_WORDS = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Go,
  input  logic                 Img_Valid,
  input  logic [D_WIDTH-1:0]   Img_Data,
  output logic                 Img_Ready,
  output logic                 Rst_M,
  output logic [SA_WIDTH-1:0]  Addr,
  output logic [D_WIDTH-1:0]   Data_I,
  input  logic [D_WIDTH-1:0]   Data_O,
  output logic                 En,
  output logic                 RW,
  output logic                 Gpp_Rst,
  output logic                 Gpp_Str,
  input  logic                 Gpp_Done,
  output logic                 Busy,
  output logic                 Finished,
  output logic [CNT_WIDTH-1:0] Run_Cycles,
`ifdef GPP_BOOT_LOADER_VERIFY_EN
  output logic                 Verify_Err,
`endif
  output logic [STATE_W-1:0]   Dbg_State
);

  // One extra bit so the word index can reach NUM_WORDS when
  // NUM_WORDS == 2**SA_WIDTH.
  localparam int K_W = SA_WIDTH + 1;

  state_e               state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic                 last_q, last_d;       // final word accepted, write pending
  logic                 img_ready_q, img_ready_d;
  logic                 rst_m_q, rst_m_d;
  logic [SA_WIDTH-1:0]  addr_q, addr_d;
  logic [D_WIDTH-1:0]   data_q, data_d;
  logic                 en_q, en_d;
  logic                 rw_q, rw_d;
  logic                 gpp_rst_q, gpp_rst_d;
  logic                 gpp_str_q, gpp_str_d;
  logic                 busy_q, busy_d;
  logic                 finished_q, finished_d;

  logic                 accept;
  logic                 cnt_clr;
  logic                 cnt_en;
  logic [CNT_WIDTH-1:0] run_cycles;

`ifdef GPP_BOOT_LOADER_VERIFY_EN
  logic [D_WIDTH-1:0]   chk_q, chk_d;         // XOR of written words
  logic [D_WIDTH-1:0]   vchk_q, vchk_d;       // XOR of read-back words
  logic [K_W-1:0]       rcv_q, rcv_d;         // read-back words received
  logic                 rd_pend_q, rd_pend_d; // Data_O carries a read this cycle
  logic                 verify_err_q, verify_err_d;
`else
  logic                 unused_data_o;
  assign unused_data_o = ^Data_O;
`endif

  assign accept = Img_Valid && img_ready_q;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    last_d      = last_q;
    rst_m_d     = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    en_d        = 1'b0;
    rw_d        = 1'b0;
    gpp_rst_d   = 1'b0;
    gpp_str_d   = 1'b0;
    finished_d  = finished_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
    chk_d        = chk_q;
    vchk_d       = vchk_q;
    rcv_d        = rcv_q;
    rd_pend_d    = 1'b0;
    verify_err_d = verify_err_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (Go) begin
          state_d    = S_MEMRST;
          rst_m_d    = 1'b1;
          finished_d = 1'b0;
          cnt_clr    = 1'b1;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
          verify_err_d = 1'b0;
`endif
        end
      end

      S_MEMRST: begin
        state_d = S_LOAD;
        k_d     = '0;
        last_d  = 1'b0;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
        chk_d   = '0;
`endif
      end

      S_LOAD: begin
        if (last_q) begin
          // The final write is on the port this cycle; nothing else to take.
          state_d = S_GAP;
        end else if (accept) begin
          en_d   = 1'b1;
          rw_d   = 1'b1;
          addr_d = k_q[SA_WIDTH-1:0];
          data_d = Img_Data;
          k_d    = k_q + K_W'(1);
          if (k_q == K_W'(NUM_WORDS - 1)) begin
            last_d = 1'b1;
          end
`ifdef GPP_BOOT_LOADER_VERIFY_EN
          chk_d = chk_q ^ Img_Data;
`endif
        end
      end

      S_GAP: begin
`ifdef GPP_BOOT_LOADER_VERIFY_EN
        // First read (address 0) goes out on entry to S_VERIFY.
        state_d = S_VERIFY;
        en_d    = 1'b1;
        rw_d    = 1'b0;
        addr_d  = '0;
        k_d     = K_W'(1);
        rcv_d   = '0;
        vchk_d  = '0;
`else
        state_d   = S_CPURST;
        gpp_rst_d = 1'b1;
`endif
      end

`ifdef GPP_BOOT_LOADER_VERIFY_EN
      S_VERIFY: begin
        if (k_q < K_W'(NUM_WORDS)) begin
          en_d   = 1'b1;
          rw_d   = 1'b0;
          addr_d = k_q[SA_WIDTH-1:0];
          k_d    = k_q + K_W'(1);
        end
        // A read on the port now returns data on Data_O next cycle.
        rd_pend_d = en_q && !rw_q;
        if (rd_pend_q) begin
          vchk_d = vchk_q ^ Data_O;
          rcv_d  = rcv_q + K_W'(1);
          if (rcv_q == K_W'(NUM_WORDS - 1)) begin
            if ((vchk_q ^ Data_O) == chk_q) begin
              state_d   = S_CPURST;
              gpp_rst_d = 1'b1;
            end else begin
              state_d      = S_DONE;
              verify_err_d = 1'b1;
              finished_d   = 1'b1;
            end
          end
        end
      end
`endif

      S_CPURST: begin
        state_d   = S_RUN;
        gpp_str_d = 1'b1;
      end

      S_RUN: begin
        // The Done cycle itself is counted, so Done on the first run cycle
        // reports 1.
        cnt_en = 1'b1;
        if (Gpp_Done) begin
          state_d    = S_DONE;
          finished_d = 1'b1;
        end else begin
          gpp_str_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    img_ready_d = (state_d == S_LOAD) && !last_d;
    busy_d      = is_busy(state_d);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      last_q      <= 1'b0;
      img_ready_q <= 1'b0;
      rst_m_q     <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      en_q        <= 1'b0;
      rw_q        <= 1'b0;
      gpp_rst_q   <= 1'b0;
      gpp_str_q   <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
      chk_q        <= '0;
      vchk_q       <= '0;
      rcv_q        <= '0;
      rd_pend_q    <= 1'b0;
      verify_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      last_q      <= last_d;
      img_ready_q <= img_ready_d;
      rst_m_q     <= rst_m_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      en_q        <= en_d;
      rw_q        <= rw_d;
      gpp_rst_q   <= gpp_rst_d;
      gpp_str_q   <= gpp_str_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
      chk_q        <= chk_d;
      vchk_q       <= vchk_d;
      rcv_q        <= rcv_d;
      rd_pend_q    <= rd_pend_d;
      verify_err_q <= verify_err_d;
`endif
    end
  end

  gpp_sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_run_cnt (
    .clk (Clk),
    .rst (Rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .cnt (run_cycles)
  );

  assign Img_Ready  = img_ready_q;
  assign Rst_M      = rst_m_q;
  assign Addr       = addr_q;
  assign Data_I     = data_q;
  assign En         = en_q;
  assign RW         = rw_q;
  assign Gpp_Rst    = gpp_rst_q;
  assign Gpp_Str    = gpp_str_q;
  assign Busy       = busy_q;
  assign Finished   = finished_q;
  assign Run_Cycles = run_cycles;
  assign Dbg_State  = state_q;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
  assign Verify_Err = verify_err_q;
`endif

endmodule

// File: tb/tb_gpp_boot_loader.sv
// tb_gpp_boot_loader
//   Bench for gpp_boot_loader: an SRAM model behind the load port, an image
//   driver, a write scoreboard and a GPP Done driver. Also exercises the
//   read-back check when GPP_BOOT_LOADER_VERIFY_EN is defined.
module tb_gpp_boot_loader;
  import gpp_boot_loader_pkg::*;

  localparam int D_WIDTH   = 32;
  localparam int SA_WIDTH  = 5;
  localparam int NUM_WORDS = 32;
  localparam int CNT_WIDTH = 32;
  localparam int W         = SA_WIDTH + D_WIDTH;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
  // Gap cycle, then NUM_WORDS reads plus one cycle for the last read data.
  localparam int POST_LOAD = 2 + NUM_WORDS + 1;
`else
  localparam int POST_LOAD = 2;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic                 clk = 1'b0;
  logic                 Rst, Go, Img_Valid, Gpp_Done;
  logic [D_WIDTH-1:0]   Img_Data;
  logic                 Img_Ready, Rst_M, En, RW, Gpp_Rst, Gpp_Str, Busy, Finished;
  logic [SA_WIDTH-1:0]  Addr;
  logic [D_WIDTH-1:0]   Data_I;
  logic [D_WIDTH-1:0]   Data_O;
  logic [CNT_WIDTH-1:0] Run_Cycles;
  logic [STATE_W-1:0]   Dbg_State;
`ifdef GPP_BOOT_LOADER_VERIFY_EN
  logic                 Verify_Err;
`endif

  always #5 clk = ~clk;

  gpp_boot_loader #(
    .D_WIDTH   (D_WIDTH),
    .SA_WIDTH  (SA_WIDTH),
    .NUM_WORDS (NUM_WORDS),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .Clk        (clk),
    .Rst        (Rst),
    .Go         (Go),
    .Img_Valid  (Img_Valid),
    .Img_Data   (Img_Data),
    .Img_Ready  (Img_Ready),
    .Rst_M      (Rst_M),
    .Addr       (Addr),
    .Data_I     (Data_I),
    .Data_O     (Data_O),
    .En         (En),
    .RW         (RW),
    .Gpp_Rst    (Gpp_Rst),
    .Gpp_Str    (Gpp_Str),
    .Gpp_Done   (Gpp_Done),
    .Busy       (Busy),
    .Finished   (Finished),
    .Run_Cycles (Run_Cycles),
`ifdef GPP_BOOT_LOADER_VERIFY_EN
    .Verify_Err (Verify_Err),
`endif
    .Dbg_State  (Dbg_State)
  );

  // ---------------- SRAM model ----------------
  logic [D_WIDTH-1:0] mem [NUM_WORDS];
  logic               corrupt = 1'b0;   // flip bit 0 of word 7 on read

  always @(posedge clk) begin
    if (En) begin
      if (RW) mem[Addr] <= Data_I;
      else    Data_O    <= mem[Addr] ^ ((corrupt && (Addr == 5'd7)) ? 32'h1 : 32'h0);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, wr_cnt = 0, rst_m_cnt = 0, gpp_rst_cnt = 0, str_cnt = 0;
  int first_wr_cyc = 0, last_wr_cyc = 0, rst_m_cyc = 0, gpp_rst_cyc = 0, str_rise_cyc = 0;
  logic str_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge and run the write monitor there.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    cyc++;
    if (En === 1'b1 && RW === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("write_with_empty_queue", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("write", 64'({Addr, Data_I}), 64'(e));
      end
      if (Addr == 5'd0)                       first_wr_cyc = cyc;
      if (Addr == SA_WIDTH'(NUM_WORDS - 1))   last_wr_cyc  = cyc;
    end
    if (Rst_M)   begin rst_m_cnt++;   rst_m_cyc   = cyc; end
    if (Gpp_Rst) begin gpp_rst_cnt++; gpp_rst_cyc = cyc; end
    if (Gpp_Str) str_cnt++;
    if (Gpp_Str && !str_prev) str_rise_cyc = cyc;
    str_prev = Gpp_Str;
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    check_eq({tag, "_ctrl"}, 64'({Img_Ready, Rst_M, En, RW, Gpp_Rst, Gpp_Str, Busy, Finished}), 64'd0);
    check_eq({tag, "_addr_data"}, 64'({Addr, Data_I}), 64'd0);
    check_eq({tag, "_run_cycles"}, 64'(Run_Cycles), 64'd0);
    check_eq({tag, "_state"}, 64'(Dbg_State), 64'(S_IDLE));
  endtask

  task automatic pulse_go();
    Go = 1'b1;
    tick();
    Go = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid every other cycle, 2: random idle gaps
  task automatic load_image(input logic [D_WIDTH-1:0] base, input int n, input int mode);
    int g;
    for (int k = 0; k < n; k++) begin
      if (mode == 2) begin
        Img_Valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      Img_Valid = 1'b1;
      Img_Data  = base + D_WIDTH'(k);
      g = 0;
      while (!Img_Ready && g < 16) begin tick(); g++; end
      if (!Img_Ready) begin
        check_eq("img_ready_timeout", 64'(Img_Ready), 64'd1);
        Img_Valid = 1'b0;
        return;
      end
      exp_q.push_back({SA_WIDTH'(k), base + D_WIDTH'(k)});
      tick();
      if (mode == 1) begin
        Img_Valid = 1'b0;
        tick();
      end
    end
    Img_Valid = 1'b0;
  endtask

  // Returns at the falling edge of the first S_RUN cycle.
  task automatic wait_run(input string tag);
    for (int g = 0; g < 200 && !Gpp_Str; g++) tick();
    check_eq({tag, "_str_seen"}, 64'(Gpp_Str), 64'd1);
    check_eq({tag, "_gpp_rst_slot"}, 64'(gpp_rst_cyc - last_wr_cyc), 64'(POST_LOAD));
    check_eq({tag, "_str_slot"}, 64'(str_rise_cyc - last_wr_cyc), 64'(POST_LOAD + 1));
    check_eq({tag, "_state_run"}, 64'(Dbg_State), 64'(S_RUN));
`ifdef GPP_BOOT_LOADER_VERIFY_EN
    check_eq({tag, "_verify_err_clean"}, 64'(Verify_Err), 64'd0);
`endif
  endtask

  // Raise Done for the current run cycle and check the completion outputs.
  task automatic finish_run(input string tag, input int n);
    Gpp_Done = 1'b1;
    tick();
    Gpp_Done = 1'b0;
    check_eq({tag, "_run_cycles"}, 64'(Run_Cycles), 64'(n));
    check_eq({tag, "_done_flags"}, 64'({Finished, Gpp_Str, Busy}), 64'b100);
    check_eq({tag, "_state_done"}, 64'(Dbg_State), 64'(S_DONE));
    repeat (3) tick();
    check_eq({tag, "_run_cycles_frozen"}, 64'(Run_Cycles), 64'(n));
  endtask

  // ---------------- test sequence ----------------
  int s_rst_m, s_gpp_rst, s_wr, s_str;

  initial begin
    Rst = 1'b1; Go = 1'b0; Img_Valid = 1'b0; Img_Data = '0; Gpp_Done = 1'b0;
    repeat (3) tick();
    check_reset("in_reset");
    Rst = 1'b0;
    tick();
    check_reset("after_reset");

    // Back-to-back image, then a 100-cycle run.
    s_rst_m = rst_m_cnt; s_gpp_rst = gpp_rst_cnt; s_wr = wr_cnt;
    pulse_go();
    check_eq("t1_rst_m_busy", 64'({Rst_M, Busy}), 64'b11);
    load_image(32'h1000, NUM_WORDS, 0);
    wait_run("t1");
    check_eq("t1_wr_count", 64'(wr_cnt - s_wr), 64'(NUM_WORDS));
    check_eq("t1_wr_span", 64'(last_wr_cyc - first_wr_cyc), 64'(NUM_WORDS - 1));
    check_eq("t1_rst_m_pulses", 64'(rst_m_cnt - s_rst_m), 64'd1);
    check_eq("t1_rst_m_before_load", 64'(rst_m_cyc < first_wr_cyc), 64'd1);
    check_eq("t1_gpp_rst_pulses", 64'(gpp_rst_cnt - s_gpp_rst), 64'd1);
    check_eq("t1_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (99) tick();
    finish_run("t1", 100);

    // Restart from S_DONE, throttled image, Go/Img_Valid ignored in S_RUN.
    pulse_go();
    check_eq("t2_restart_cleared", 64'({Finished, Run_Cycles}), 64'd0);
    check_eq("t2_restart_busy", 64'(Busy), 64'd1);
    s_wr = wr_cnt;
    load_image(32'h2000, NUM_WORDS, 1);
    wait_run("t2");
    check_eq("t2_wr_count", 64'(wr_cnt - s_wr), 64'(NUM_WORDS));
    check_eq("t2_wr_span", 64'(last_wr_cyc - first_wr_cyc), 64'(2 * (NUM_WORDS - 1)));
    s_wr = wr_cnt;
    Go = 1'b1; Img_Valid = 1'b1; Img_Data = 32'hBAD0_BAD0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("t2_run_ready_low", 64'(Img_Ready), 64'd0);
      check_eq("t2_run_state", 64'({Dbg_State, Gpp_Str}), 64'({S_RUN, 1'b1}));
    end
    Go = 1'b0; Img_Valid = 1'b0;
    check_eq("t2_run_no_writes", 64'(wr_cnt - s_wr), 64'd0);
    finish_run("t2", 6);

    // Abort after 10 words, then a full reload and Done on the first run cycle.
    pulse_go();
    load_image(32'h3000, 10, 2);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    check_reset("abort");
    check_eq("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    s_wr = wr_cnt;
    repeat (4) tick();
    check_eq("abort_no_writes", 64'(wr_cnt - s_wr), 64'd0);
    pulse_go();
    load_image(32'h4000 + 32'($urandom_range(0, 255)), NUM_WORDS, 2);
    wait_run("t3");
    check_eq("t3_queue_empty", 64'(exp_q.size()), 64'd0);
    finish_run("t3", 1);

`ifdef GPP_BOOT_LOADER_VERIFY_EN
    // Corrupted read-back: no GPP reset/start, sticky error.
    corrupt = 1'b1;
    s_gpp_rst = gpp_rst_cnt; s_str = str_cnt;
    pulse_go();
    load_image(32'h5000, NUM_WORDS, 0);
    for (int g = 0; g < 200 && !Finished; g++) tick();
    check_eq("v_finished", 64'(Finished), 64'd1);
    check_eq("v_verify_err", 64'(Verify_Err), 64'd1);
    check_eq("v_no_gpp_rst", 64'(gpp_rst_cnt - s_gpp_rst), 64'd0);
    check_eq("v_no_gpp_str", 64'(str_cnt - s_str), 64'd0);
    check_eq("v_state_done", 64'(Dbg_State), 64'(S_DONE));
    corrupt = 1'b0;
    pulse_go();
    check_eq("v_err_cleared", 64'(Verify_Err), 64'd0);
    load_image(32'h6000, NUM_WORDS, 0);
    wait_run("v_clean");
    finish_run("v_clean", 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpp_boot_loader.md
Name: gpp_boot_loader

Overview:
- Hardware program loader sitting directly upstream of GPP_TOP.
- Accepts a program image as a valid/ready word stream and writes it word-by-word into the GPP instruction SRAM through the SRAM load port (Addr/Data_I/En/RW/Rst_M).
- Then pulses GPP reset, asserts start, waits for GPP Done and reports completion plus run-cycle count.
- Replaces bench-driven SRAM loading so the GPP can boot from an external source.

Parameters:
- D_WIDTH, 32, data word width (matches `D_WIDTH in define.h).
- SA_WIDTH, 5, SRAM address width (matches `SA_WIDTH).
- NUM_WORDS, 32, words per image (matches `SL_WIDTH); at most 2^SA_WIDTH.
- CNT_WIDTH, 32, width of the run-cycle counter.

Ports:
- Clk  in  1  system clock; single clock domain.
- Rst  in  1  reset; synchronous, active-high.
- Go  in  1  start request; sampled only in S_IDLE or S_DONE.
- Img_Valid  in  1  image word valid.
- Img_Data  in  D_WIDTH  image word.
- Img_Ready  out  1  loader accepts a word this cycle.
- Rst_M  out  1  SRAM reset to GPP_TOP.
- Addr  out  SA_WIDTH  SRAM address to GPP_TOP.
- Data_I  out  D_WIDTH  SRAM write data to GPP_TOP.
- Data_O  in  D_WIDTH  SRAM read data from GPP_TOP; used only with the optional feature.
- En  out  1  SRAM enable.
- RW  out  1  SRAM direction; 1 = write, 0 = read.
- Gpp_Rst  out  1  GPP core reset.
- Gpp_Str  out  1  GPP start.
- Gpp_Done  in  1  GPP finished.
- Busy  out  1  loader is in any state other than S_IDLE or S_DONE.
- Finished  out  1  sticky run complete.
- Run_Cycles  out  CNT_WIDTH  cycles from first Gpp_Str to Gpp_Done; saturating.

Behaviour:
- All outputs are registered.
- Reset: every output is 0 and state is S_IDLE. Rst mid-operation aborts immediately; no partial writes follow.
- S_IDLE: Go=1 -> S_MEMRST; Finished and Run_Cycles are cleared on that edge.
- S_MEMRST: Rst_M=1 for exactly 1 cycle, then word index k=0 -> S_LOAD.
- S_LOAD:
  - Img_Ready=1 (combinational from state).
  - A word is accepted when Img_Valid&&Img_Ready. The cycle after acceptance drives En=1, RW=1, Addr=k, Data_I=word.
  - Cycles without acceptance drive En=0, RW=0; Addr and Data_I hold.
  - k increments per accepted word. Back-to-back acceptance gives one write per cycle.
  - After word NUM_WORDS-1 is accepted: Img_Ready=0 from the next cycle, its write is issued, then -> S_GAP.
- S_GAP: En=0, RW=0 for 1 cycle -> S_CPURST.
- S_CPURST: Gpp_Rst=1 for exactly 1 cycle -> S_RUN.
- S_RUN:
  - Gpp_Str=1 held continuously; Run_Cycles increments each cycle and saturates at all-ones.
  - Gpp_Done=1 -> S_DONE. Gpp_Str drops and the counter freezes on that edge.
  - Gpp_Done already high on the first S_RUN cycle gives Run_Cycles=1.
- S_DONE: Finished=1. Go=1 -> S_MEMRST (restart, counters cleared).
- Go while Busy: ignored.
- Img_Valid outside S_LOAD: ignored; Img_Ready=0.
- Address never wraps: k counts 0..NUM_WORDS-1 only.

Optional Feature:
- Macro: GPP_BOOT_LOADER_VERIFY_EN.
- With the macro defined:
  - The loader keeps an XOR checksum of written words.
  - After S_GAP it enters S_VERIFY: reads addresses 0..NUM_WORDS-1 with En=1, RW=0, one per cycle.
  - Data_O is valid the cycle after the read and is XOR-accumulated.
  - On a checksum match -> S_CPURST.
  - On a mismatch: extra output Verify_Err (1 bit, sticky, reset 0, cleared on Go) =1 -> S_DONE without pulsing Gpp_Rst or Gpp_Str; Finished=1.
- Without the macro: there is no S_VERIFY, no Verify_Err port, and Data_O is unused.

Decomposition:
- define.h gains the state encodings (S_IDLE, S_MEMRST, S_LOAD, S_GAP, S_VERIFY, S_CPURST, S_RUN, S_DONE) as `define constants, plus the default NUM_WORDS tied to `SL_WIDTH.
- One natural sub-module: gpp_sat_counter (parameterised width, clear/enable, saturating) for Run_Cycles.

Test Plan:
- Reset then Go with 32 back-to-back valid words 0x1000+k -> Rst_M pulses 1 cycle; 32 consecutive writes Addr=0..31, Data_I=0x1000..0x101F; then 1 gap cycle, Gpp_Rst for 1 cycle, Gpp_Str high.
- Img_Valid deasserted every other cycle -> En=1 only the cycle after each acceptance; the address sequence stays contiguous 0..31; no duplicate writes.
- Gpp_Done raised 100 cycles after Gpp_Str -> Run_Cycles=100, Finished=1, Gpp_Str=0, Busy=0; a second Go restarts with Run_Cycles cleared.
- Rst asserted during S_LOAD at k=10 -> next cycle all outputs 0, state S_IDLE; a later Go reloads from Addr=0.
- Go pulsed during S_RUN and Img_Valid held high in S_RUN -> no state change, Img_Ready=0, no writes.
- With GPP_BOOT_LOADER_VERIFY_EN, an SRAM model corrupting word 7 on read -> Verify_Err=1, Gpp_Rst and Gpp_Str never asserted, Finished=1; the clean model proceeds to S_RUN.
